// File: rtl/subtractor_tougaw_serial_if.sv
// Handshake and result bundle for the bit-serial majority-gate subtractor.
// The requester drives start/a/b; the subtractor returns status and results.
interface subtractor_tougaw_serial_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] bo;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  ready, busy, done, d, bo, borrow_out
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, d, bo, borrow_out
  );
endinterface

// File: rtl/subtractor_tougaw_serial.sv
// Bit-serial WIDTH-bit subtractor d = a - b, LSB first, one bit per clock.
// The bit cell is built only from 3-input majority gates and inverters.
// Results (d, bo, borrow_out) change only on the edge that enters DONE.
module subtractor_tougaw_serial #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  subtractor_tougaw_serial_if.slave  bus
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] bor_sh_q, bor_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] bo_q, bo_d;
  logic             cell_diff_s;
  logic             cell_bout_s;

  // Three-input majority gate, the only logic primitive of the cell.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // XOR3 from majority gates: the inverted majority steers the output
  // between x|y (z=0) and x&y (z=1), giving the odd-parity function.
  function automatic logic xor3_maj(input logic x, input logic y, input logic z);
    return maj(~maj(x, y, z), z, maj(x, y, ~z));
  endfunction

  // Subtractor bit cell on the current LSBs of the shifting operands.
  always_comb begin
    cell_bout_s = maj(~a_q[0], b_q[0], borrow_q);
    cell_diff_s = xor3_maj(a_q[0], b_q[0], borrow_q);
  end

  // Next-state and datapath-update logic for IDLE -> RUN -> DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_sh_d = diff_sh_q;
    bor_sh_d  = bor_sh_q;
    diff_d    = diff_q;
    bo_d      = bo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        // Operands shift right so bit idx is always at position 0; results
        // enter from the MSB so after WIDTH shifts bit 0 lands at position 0.
        diff_sh_d = (diff_sh_q >> 1) | (WIDTH'(cell_diff_s) << (WIDTH - 1));
        bor_sh_d  = (bor_sh_q >> 1) | (WIDTH'(cell_bout_s) << (WIDTH - 1));
        a_d       = a_q >> 1;
        b_d       = b_q >> 1;
        borrow_d  = cell_bout_s;
        idx_d     = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          diff_d  = diff_sh_d;
          bo_d    = bor_sh_d;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff_sh_q <= '0;
      bor_sh_q  <= '0;
      diff_q    <= '0;
      bo_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_sh_q <= diff_sh_d;
      bor_sh_q  <= bor_sh_d;
      diff_q    <= diff_d;
      bo_q      <= bo_d;
    end
  end

  assign bus.ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.d          = diff_q;
  assign bus.bo         = bo_q;
  assign bus.borrow_out = bo_q[WIDTH-1];

endmodule

// File: tb/tb_subtractor_tougaw_serial.sv
// Bench for the bit-serial subtractor: three instances (WIDTH 4, 1, 8) are
// compared every cycle against an arithmetic model, plus literal checks.
module tb_subtractor_tougaw_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Per-instance stimulus (index 0: WIDTH=4, 1: WIDTH=1, 2: WIDTH=8).
  logic       st [3];
  logic       rs [3];
  logic [7:0] av [3];
  logic [7:0] bv [3];
  // Per-instance observed outputs, zero-extended to 8 bits.
  logic       o_rdy  [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic       o_bout [3];
  logic [7:0] o_d    [3];
  logic [7:0] o_bo   [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);

    subtractor_tougaw_serial_if #(.WIDTH(W)) ifc ();

    subtractor_tougaw_serial #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rs[gi]),
      .bus (ifc)
    );

    assign ifc.start  = st[gi];
    assign ifc.a      = av[gi][W-1:0];
    assign ifc.b      = bv[gi][W-1:0];
    assign o_rdy[gi]  = ifc.ready;
    assign o_busy[gi] = ifc.busy;
    assign o_done[gi] = ifc.done;
    assign o_bout[gi] = ifc.borrow_out;
    assign o_d[gi]    = 8'(ifc.d);
    assign o_bo[gi]   = 8'(ifc.bo);

    // Model: operation timing as a countdown, results from plain arithmetic.
    logic       mvalid, mready, mbusy, mdone, mbout;
    logic [7:0] md, mbo;
    int         ca, cb, left, msk;

    initial begin
      mvalid = 1'b0; mready = 1'b1; mbusy = 1'b0; mdone = 1'b0; mbout = 1'b0;
      md = 8'd0; mbo = 8'd0; left = 0; ca = 0; cb = 0;
      msk = (1 << W) - 1;
      forever begin
        @(negedge clk);
        if (mvalid) begin
          chk($sformatf("W%0d cycle %0d", W, cyc),
              {12'd0, o_rdy[gi], o_busy[gi], o_done[gi], o_bout[gi], o_bo[gi], o_d[gi]},
              {12'd0, mready, mbusy, mdone, mbout, mbo, md});
        end
        // Advance the model with the inputs the coming edge will sample.
        if (rs[gi]) begin
          mvalid = 1'b1; mready = 1'b1; mbusy = 1'b0; mdone = 1'b0;
          mbout = 1'b0; md = 8'd0; mbo = 8'd0; left = 0;
        end else if (mvalid) begin
          if (mready && st[gi]) begin
            ca = int'(av[gi]) & msk;
            cb = int'(bv[gi]) & msk;
            mready = 1'b0; mbusy = 1'b1; mdone = 1'b0; left = W;
          end else if (mbusy) begin
            left--;
            if (left == 0) begin
              mbusy = 1'b0; mready = 1'b1; mdone = 1'b1;
              md    = 8'((ca - cb) & msk);
              mbout = (ca < cb);
              mbo   = 8'd0;
              for (int i = 0; i < W; i++)
                mbo[i] = ((ca % (1 << (i + 1))) < (cb % (1 << (i + 1))));
            end
          end else begin
            mdone = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present an operation and let one edge accept it (instance must be ready).
  task automatic launch(input int k, input logic [7:0] a, input logic [7:0] b);
    av[k] = a; bv[k] = b; st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(input int k, output int lat);
    bit ok;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      lat++;
      if (o_done[k]) ok = 1'b1;
    end
    chk("done within budget", 32'(ok), 32'd1);
  endtask

  task automatic op_check(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic [7:0] ebo, input logic eb);
    int lat;
    launch(0, a, b);
    wait_done(0, lat);
    chk({nm, " latency"}, 32'(lat), 32'd4);
    chk({nm, " d"}, 32'(o_d[0]), 32'(ed));
    chk({nm, " bo"}, 32'(o_bo[0]), 32'(ebo));
    chk({nm, " borrow_out"}, 32'(o_bout[0]), 32'(eb));
  endtask

  // Back-to-back exhaustive sweep: next start is presented in the DONE cycle.
  task automatic exhaustive(input int k, input int w);
    for (int a = 0; a < (1 << w); a++) begin
      for (int b = 0; b < (1 << w); b++) begin
        av[k] = 8'(a); bv[k] = 8'(b); st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
        for (int i = 0; i < w; i++) begin
          av[k] = 8'($urandom); bv[k] = 8'($urandom);
          tick();
        end
      end
    end
  endtask

  task automatic rand_cycles(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      st[k] = ($urandom_range(0, 2) == 0);
      av[k] = 8'($urandom);
      bv[k] = 8'($urandom);
      rs[k] = ($urandom_range(0, 127) == 0);
      tick();
    end
    st[k] = 1'b0;
    rs[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int pulses;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; rs[k] = 1'b1; av[k] = 8'd0; bv[k] = 8'd0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) rs[k] = 1'b0;

    chk("reset ready", 32'(o_rdy[0]), 32'd1);
    chk("reset busy", 32'(o_busy[0]), 32'd0);
    chk("reset done", 32'(o_done[0]), 32'd0);
    chk("reset d", 32'(o_d[0]), 32'd0);

    op_check("9-3", 8'd9, 8'd3, 8'd6, 8'b0110, 1'b0);
    op_check("3-9", 8'd3, 8'd9, 8'd10, 8'b1000, 1'b1);
    op_check("0-1", 8'd0, 8'd1, 8'd15, 8'b1111, 1'b1);
    op_check("5-5", 8'd5, 8'd5, 8'd0, 8'd0, 1'b0);

    // Start pulses and operand changes while busy are ignored.
    launch(0, 8'd12, 8'd5);
    for (int i = 0; i < 3; i++) begin
      st[0] = 1'b1; av[0] = 8'($urandom); bv[0] = 8'($urandom);
      tick();
    end
    st[0] = 1'b0;
    wait_done(0, lat);
    chk("busy-ignore latency", 32'(lat + 3), 32'd4);
    chk("12-5 d", 32'(o_d[0]), 32'd7);
    chk("12-5 bo", 32'(o_bo[0]), 32'b0111);

    // Start during the DONE cycle begins the next op immediately.
    launch(0, 8'd2, 8'd7);
    chk("restart no early done", 32'(o_done[0]), 32'd0);
    chk("restart busy", 32'(o_busy[0]), 32'd1);
    wait_done(0, lat);
    chk("2-7 latency", 32'(lat), 32'd4);
    chk("2-7 d", 32'(o_d[0]), 32'd11);
    chk("2-7 bo", 32'(o_bo[0]), 32'b1111);
    chk("2-7 borrow_out", 32'(o_bout[0]), 32'd1);

    // Reset in the second RUN cycle discards the op.
    launch(0, 8'd6, 8'd1);
    tick();
    rs[0] = 1'b1;
    tick();
    rs[0] = 1'b0;
    chk("midrun rst ready", 32'(o_rdy[0]), 32'd1);
    chk("midrun rst busy", 32'(o_busy[0]), 32'd0);
    chk("midrun rst d", 32'(o_d[0]), 32'd0);
    chk("midrun rst bo", 32'(o_bo[0]), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_done[0]) pulses++;
      tick();
    end
    chk("midrun rst no done", 32'(pulses), 32'd0);
    op_check("6-1", 8'd6, 8'd1, 8'd5, 8'b0001, 1'b0);

    exhaustive(0, 4);
    exhaustive(1, 1);
    fork
      rand_cycles(0, 3000);
      rand_cycles(1, 3000);
      rand_cycles(2, 12000);
    join
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
